// File: rtl/block_mac_2x2_if.sv
// block_mac_2x2_if: operand/result handshake bundle for the 2x2 block MAC.
//   in_valid/in_ready : operand-pair handshake (upstream -> unit)
//   in_first/in_last  : tile framing for the pair (clear before / present after)
//   a00..a11, b00..b11: 2x2 operand sub-blocks, (row, col)
//   out_valid/out_ready: result-tile handshake (unit -> write-back)
//   c00..c11          : accumulator contents
// master = upstream/consumer side, slave = the MAC unit.
interface block_mac_2x2_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_first;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] a00, a01, a10, a11;
    logic [DATA_WIDTH-1:0] b00, b01, b10, b11;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] c00, c01, c10, c11;

    modport master (
        output in_valid, in_first, in_last,
        output a00, a01, a10, a11, b00, b01, b10, b11,
        output out_ready,
        input  in_ready, out_valid,
        input  c00, c01, c10, c11
    );

    modport slave (
        input  in_valid, in_first, in_last,
        input  a00, a01, a10, a11, b00, b01, b10, b11,
        input  out_ready,
        output in_ready, out_valid,
        output c00, c01, c10, c11
    );
endinterface

// File: rtl/block_mac_2x2.sv
// block_mac_2x2: accumulates C += A*B over a stream of 2x2 sub-block pairs
// using a single time-shared multiplier (8 multiply-adds per pair).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : block_mac_2x2_if.slave (operand handshake in, result tile out)
// Accepts a pair only in IDLE, spends 8 cycles in MUL, then either returns to
// IDLE (more pairs for this tile) or sits in OUT until the consumer takes C.
module block_mac_2x2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    block_mac_2x2_if.slave  bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Element index = row*2 + col, so [0]=x00, [1]=x01, [2]=x10, [3]=x11.
    typedef logic [3:0][W-1:0] blk_t;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    blk_t       a_q, a_d;
    blk_t       b_q, b_d;
    blk_t       acc_q, acc_d;
    logic       last_q, last_d;

    // k decodes as i=k[2], j=k[1], m=k[0]; term is c_ij += a_im * b_mj.
    logic [1:0]   a_idx, b_idx, acc_idx;
    logic [W-1:0] prod_lo;

    assign a_idx   = {k_q[2], k_q[0]};
    assign b_idx   = {k_q[0], k_q[1]};
    assign acc_idx = {k_q[2], k_q[1]};

    // Only the low W bits of the signed 2W-bit product are kept; those bits
    // are identical for signed and unsigned multiplication, so a W-bit
    // multiply gives the truncated signed product directly.
    assign prod_lo = a_q[a_idx] * b_q[b_idx];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = {bus.a11, bus.a10, bus.a01, bus.a00};
                    b_d     = {bus.b11, bus.b10, bus.b01, bus.b00};
                    last_d  = bus.in_last;
                    k_d     = '0;
                    state_d = MUL;
                    if (bus.in_first) begin
                        acc_d = '0;
                    end
                end
            end
            MUL: begin
                acc_d[acc_idx] = acc_q[acc_idx] + prod_lo;
                k_d            = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                // Accumulators stay put on exit; the next in_first clears them.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
        end
    end

    // Handshake outputs decode state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.c00       = acc_q[0];
    assign bus.c01       = acc_q[1];
    assign bus.c10       = acc_q[2];
    assign bus.c11       = acc_q[3];
endmodule

// File: tb/tb_block_mac_2x2.sv
module tb_block_mac_2x2;
    localparam int W = 32;
    typedef logic [3:0][W-1:0] tile_t;   // [0]=x00 [1]=x01 [2]=x10 [3]=x11

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    block_mac_2x2_if #(.DATA_WIDTH(W)) bus ();
    block_mac_2x2 #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    tile_t exp_q[$];
    tile_t model;
    int    total = 0;
    int    bad   = 0;

    function automatic tile_t mk(input logic [W-1:0] x00, x01, x10, x11);
        return {x11, x10, x01, x00};
    endfunction

    function automatic tile_t cur_c();
        return {bus.c11, bus.c10, bus.c01, bus.c00};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input tile_t e);
        tile_t c;
        c = cur_c();
        chk({tag, "_c00"}, c[0], e[0]);
        chk({tag, "_c01"}, c[1], e[1]);
        chk({tag, "_c10"}, c[2], e[2]);
        chk({tag, "_c11"}, c[3], e[3]);
    endtask

    // Reference: C += A*B with 32-bit wrap (low bits of the signed product).
    task automatic model_pair(input tile_t a, input tile_t b, input bit first);
        if (first) model = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int m = 0; m < 2; m++)
                    model[i*2+j] = model[i*2+j] + a[i*2+m] * b[m*2+j];
    endtask

    task automatic drive_ops(input tile_t a, input tile_t b);
        {bus.a11, bus.a10, bus.a01, bus.a00} = a;
        {bus.b11, bus.b10, bus.b01, bus.b00} = b;
    endtask

    // Returns at the negedge right after the accepting edge (k=0 in MUL).
    task automatic send_pair(input tile_t a, input tile_t b, input bit first, input bit last);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", (n < 100) ? 1 : 0, 1);
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        drive_ops(a, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Operands may change after acceptance without affecting the result.
        drive_ops({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        bus.in_first = 1'($urandom);
        bus.in_last  = 1'($urandom);
        model_pair(a, b, first);
        if (last) exp_q.push_back(model);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_timeout", (cyc < 100) ? 1 : 0, 1);
    endtask

    task automatic check_out(input string tag);
        tile_t e;
        chk({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_c(tag, e);
        end
    endtask

    tile_t a1, b1, id, hold;
    int    cyc, n, ov_seen;

    initial begin
        a1 = mk(1, 2, 3, 4);
        b1 = mk(5, 6, 7, 8);
        id = mk(1, 0, 0, 1);
        model = '0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;
        drive_ops('0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk_c("rst", mk(0, 0, 0, 0));
        reset = 1'b1;
        @(negedge clk);

        // Single-pair tile
        send_pair(a1, b1, 1, 1);
        wait_out(cyc);
        chk("lat_single", cyc, 8);
        check_out("single");
        chk_c("single_const", mk(19, 22, 43, 50));
        @(negedge clk);
        chk("single_in_ready", bus.in_ready, 1);
        chk("single_out_valid", bus.out_valid, 0);

        // Two-pair accumulate
        send_pair(a1, b1, 1, 0);
        n = 0;
        ov_seen = 0;
        while (!bus.in_ready && n < 100) begin
            if (bus.out_valid) ov_seen = 1;
            @(negedge clk);
            n++;
        end
        chk("busy_cycles", n, 8);
        chk("busy_no_out_valid", ov_seen, 0);
        chk("nonlast_out_valid", bus.out_valid, 0);
        send_pair(id, id, 0, 1);
        wait_out(cyc);
        check_out("acc2");
        chk_c("acc2_const", mk(20, 22, 43, 51));

        // Fresh tile: no carry-over
        send_pair(id, id, 1, 1);
        wait_out(cyc);
        check_out("fresh");
        chk_c("fresh_const", id);

        // Signed and wrap
        send_pair(mk(32'hFFFF_FFFD, 0, 0, 0), mk(4, 0, 0, 0), 1, 1);
        wait_out(cyc);
        check_out("signed");
        chk_c("signed_const", mk(32'hFFFF_FFF4, 0, 0, 0));
        send_pair(mk(32'h8000_0000, 0, 0, 0), mk(2, 0, 0, 0), 1, 1);
        wait_out(cyc);
        check_out("wrap");
        chk_c("wrap_const", mk(0, 0, 0, 0));

        // Backpressure with ignored in_valid pulses
        @(negedge clk);
        bus.out_ready = 1'b0;
        send_pair(a1, b1, 1, 1);
        wait_out(cyc);
        hold = cur_c();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            drive_ops({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk_c("bp_hold", hold);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check_out("bp");
        @(negedge clk);
        chk("bp_rel_out_valid", bus.out_valid, 0);
        chk("bp_rel_in_ready", bus.in_ready, 1);

        // Reset mid-operation at k=4
        send_pair(a1, b1, 1, 1);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk_c("midrst", mk(0, 0, 0, 0));
        void'(exp_q.pop_back());
        model = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_pair(a1, b1, 1, 1);
        wait_out(cyc);
        check_out("post_rst");
        chk_c("post_rst_const", mk(19, 22, 43, 50));

        // in_first=0 on the first pair after reset accumulates onto zero
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model = '0;
        @(negedge clk);
        send_pair(a1, b1, 0, 1);
        wait_out(cyc);
        check_out("nofirst");
        chk_c("nofirst_const", mk(19, 22, 43, 50));

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/block_mac_2x2.md
# block_mac_2x2

2x2 block multiply-accumulate unit. It sits directly downstream of the matrix-multiplication controller, which instantiates three copies. The controller streams pairs of 2x2 sub-blocks (A from the first matrix, B from the second) along the shared dimension. This unit accumulates C += A·B with one time-shared multiplier and presents the finished 2x2 result tile for write-back to memory.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width (signed two's complement)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  unit can accept a pair; high only in IDLE
- in_first  in  1  first pair of a tile: clear accumulator before adding
- in_last  in  1  last pair of a tile: present result after adding
- a00, a01, a10, a11  in  DATA_WIDTH each  A sub-block (row, col)
- b00, b01, b10, b11  in  DATA_WIDTH each  B sub-block
- out_valid  out  1  result tile valid
- out_ready  in  1  consumer takes result
- c00, c01, c10, c11  out  DATA_WIDTH each  accumulator contents

## Operation
- States: IDLE, MUL, OUT.
- **IDLE:** in_ready=1.
  - On in_valid: latch all eight operands and in_last.
  - If in_first, zero all four accumulators on the same edge.
  - Go to MUL with k=0.
- **MUL:** 3-bit counter k, one multiply-add per cycle.
  - Term: i=k[2], j=k[1], m=k[0]; c_ij <= c_ij + a_im·b_mj.
  - When k=7 completes: go to OUT if the latched in_last=1, else go to IDLE.
- **OUT:** out_valid=1 and c* held stable.
  - On out_ready: go to IDLE.
  - Accumulators are not cleared on exit; the next in_first clears them.
- **Arithmetic:** full 2·DATA_WIDTH signed product, truncated to the low DATA_WIDTH bits, added modulo 2^DATA_WIDTH. No saturation and no overflow flag.
- **Handshake outputs:** in_ready and out_valid decode state only. They never depend combinationally on in_valid or out_ready.
- c* are driven from the accumulators at all times. They are meaningful only while out_valid=1.

## Timing
- **Reset** (asynchronous, reset=0):
  - state=IDLE, so in_ready=1 and out_valid=0.
  - k=0; c00..c11=0; latched operands=0.
  - Takes effect immediately, including mid-MUL or in OUT; the partial sum is discarded.
- **Latency:**
  - Accept at edge N; the eight accumulate edges are N+1..N+8.
  - Last pair: out_valid=1 after edge N+8.
  - Non-last pair: in_ready=1 after edge N+8.
- **Throughput:** one pair per 9 cycles when in_valid is held high.
- **Backpressure:** OUT is held indefinitely while out_ready=0, with c* unchanged. After the edge where out_ready=1 is sampled in OUT: out_valid=0 and in_ready=1.
- **Boundary conditions:**
  - in_valid while not IDLE is ignored; the upstream must hold data until in_ready.
  - out_ready outside OUT has no effect.
  - in_first=1 with in_last=1 is a single-pair tile.
  - in_first=0 on the first pair after reset accumulates onto zero.
  - Operand inputs may change after acceptance without affecting the result.

## Test plan
- **Single-pair tile:** A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_first=in_last=1, out_ready=1 → out_valid rises 8 cycles after accept with C=[[19,22],[43,50]]. in_ready=1 one cycle later.
- **Two-pair accumulate:**
  - Send the pair above with in_first=1, in_last=0.
  - in_ready must return to 1 after exactly 8 busy cycles, with out_valid staying 0.
  - Send A=B=identity with in_last=1 → C=[[20,22],[43,51]].
  - A third pair with in_first=1 (A=B=identity, last) → C=identity; no carry-over.
- **Signed and wrap:**
  - a00=0xFFFFFFFD (−3), b00=4, all other operands 0 → c00=0xFFFFFFF4, others 0.
  - a00=0x80000000, b00=2 → c00=0x00000000.
- **Backpressure:**
  - Single-pair tile with out_ready=0 for 5 cycles → out_valid, c* and in_ready=0 all stable.
  - in_valid pulses during this window are ignored.
  - Raise out_ready → IDLE on the next edge.
- **Reset mid-operation:**
  - Assert reset while k=4 → all outputs zero and in_ready=1 immediately.
  - After release, a single-pair tile of the first scenario yields [[19,22],[43,50]].
